// File: rtl/vram_scanout_if.sv
// rtl/vram_scanout_if.sv - VRAM display read port bundle
//
// Purpose: groups the VRAM second (display) read port signals.
// Ports (signals):
//   vram_rd_en  read strobe, driven by the scanout engine
//   vram_addr   word offset into the framebuffer
//   vram_data   read data, valid one clock after vram_rd_en
// Modports:
//   master  scanout side (drives strobe and address)
//   slave   VRAM side (returns data)
interface vram_scanout_if #(
  parameter int ADDR_W = 10
) ();
  logic              vram_rd_en;
  logic [ADDR_W-1:0] vram_addr;
  logic [15:0]       vram_data;

  modport master (output vram_rd_en, output vram_addr, input  vram_data);
  modport slave  (input  vram_rd_en, input  vram_addr, output vram_data);
endinterface

// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - framebuffer scanout engine producing a raster with syncs
//
// Purpose: reads the 16-pixel-per-word framebuffer through the VRAM display
// port and streams it out MSB first as a monochrome raster with hsync/vsync.
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   enable       scanout enable, only looked at on frame boundaries
//   vram         VRAM read port (master side)
//   pixel        pixel value, 0 outside the visible area
//   pixel_valid  high while pixel is in the visible area
//   hsync        horizontal sync, active high
//   vsync        vertical sync, active high
//   frame_start  one-clock pulse with the first visible pixel of a frame
module vram_scanout #(
  parameter int H_ACTIVE    = 128,
  parameter int H_TOTAL     = 160,
  parameter int HSYNC_START = 136,
  parameter int HSYNC_LEN   = 8,
  parameter int V_ACTIVE    = 128,
  parameter int V_TOTAL     = 136,
  parameter int VSYNC_START = 130,
  parameter int VSYNC_LEN   = 2,
  parameter int ADDR_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  vram_scanout_if.master vram,
  output logic           pixel,
  output logic           pixel_valid,
  output logic           hsync,
  output logic           vsync,
  output logic           frame_start
);

  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int WPL = H_ACTIVE / 16;

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(HSYNC_START);
  localparam logic [HW-1:0] HS_END = HW'(HSYNC_START + HSYNC_LEN);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(VSYNC_START);
  localparam logic [VW-1:0] VS_END = VW'(VSYNC_START + VSYNC_LEN);

  if (H_ACTIVE % 16 != 0) begin : g_chk_hact_mult
    $error("H_ACTIVE must be a multiple of 16");
  end
  if (H_ACTIVE >= H_TOTAL) begin : g_chk_htotal
    $error("H_ACTIVE must be less than H_TOTAL");
  end
  if (V_ACTIVE >= V_TOTAL) begin : g_chk_vtotal
    $error("V_ACTIVE must be less than V_TOTAL");
  end
  if (WPL * V_ACTIVE > 2 ** ADDR_W) begin : g_chk_addr
    $error("framebuffer does not fit in ADDR_W address space");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic          run, visible;

  // Stage 1 holds the timing flags for the counters of the previous clock;
  // stage 2 (the outputs) lines up with the shift register contents.
  logic        vis_d1, hs_d1, vs_d1, fs_d1, load_d1;
  logic [15:0] shift_reg;

  assign run     = (state == RUN);
  assign visible = run && (h < H_ACT) && (v < V_ACT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_nxt;
      h     <= h_nxt;
      v     <= v_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    h_nxt           = h;
    v_nxt           = v;
    vram.vram_rd_en = 1'b0;
    vram.vram_addr  = '0;
    case (state)
      IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        // One fetch at the first pixel of each 16-pixel word.
        if (visible && (h[3:0] == 4'd0)) begin
          vram.vram_rd_en = 1'b1;
          vram.vram_addr  = ADDR_W'(v) * ADDR_W'(WPL) + ADDR_W'(h >> 4);
        end
        if (h == H_LAST) begin
          h_nxt = '0;
          if (v == V_LAST) begin
            v_nxt = '0;
            // enable only decides at the frame boundary
            if (!enable) state_nxt = IDLE;
          end else begin
            v_nxt = v + 1'b1;
          end
        end else begin
          h_nxt = h + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vis_d1      <= 1'b0;
      hs_d1       <= 1'b0;
      vs_d1       <= 1'b0;
      fs_d1       <= 1'b0;
      load_d1     <= 1'b0;
      pixel_valid <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      shift_reg   <= '0;
    end else begin
      vis_d1      <= visible;
      hs_d1       <= run && (h >= HS_BEG) && (h < HS_END);
      vs_d1       <= run && (v >= VS_BEG) && (v < VS_END);
      fs_d1       <= run && (h == '0) && (v == '0);
      load_d1     <= vram.vram_rd_en;
      pixel_valid <= vis_d1;
      hsync       <= hs_d1;
      vsync       <= vs_d1;
      frame_start <= fs_d1;
      // Read data arrives the clock after the strobe; load it then, else shift.
      if (load_d1) shift_reg <= vram.vram_data;
      else         shift_reg <= {shift_reg[14:0], 1'b0};
    end
  end

  assign pixel = pixel_valid & shift_reg[15];

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - directed bench for vram_scanout
module tb_vram_scanout;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic pixel, pixel_valid, hsync, vsync, frame_start;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] mem [1024];

  vram_scanout_if #(.ADDR_W(10)) vif ();

  vram_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .vram        (vif),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // VRAM model: one-clock read latency; junk when not strobed.
  always @(posedge clk) begin
    if (vif.vram_rd_en) vif.vram_data <= mem[vif.vram_addr];
    else                vif.vram_data <= 16'hDEAD;
  end

  wire [5:0] outs = {vif.vram_rd_en, pixel, pixel_valid, hsync, vsync, frame_start};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int   t, s, hh, vv, ph, pv, exp_addr;
    int   reads, last_rd, e_rd, e_pix, e_pv, e_hs, e_vs, e_fs, hs_cnt, vs_cnt, e_idle;
    logic exp_rd, exp_pv, exp_pix, exp_hs, exp_vs, exp_fs;

    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 40503) ^ 16'hA5C3;
    mem[0] = 16'h8001;
    reads = 0; last_rd = 0; e_rd = 0; e_pix = 0; e_pv = 0; e_hs = 0; e_vs = 0;
    e_fs = 0; hs_cnt = 0; vs_cnt = 0; e_idle = 0; ph = 0; pv = 0;

    // 1: reset held with enable high
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) begin
      step();
      chk("reset_outs", 32'(outs), 0);
    end

    // 2/3: release reset, run frame 0 against the timing model, into frame 1
    reset = 1'b1;
    for (t = 0; t <= 21762; t++) begin
      step();
      hh = t % 160;
      vv = (t / 160) % 136;
      exp_rd = (hh < 128) && (vv < 128) && (hh % 16 == 0);
      exp_addr = exp_rd ? (vv * 8 + hh / 16) : 0;
      if (vif.vram_rd_en !== exp_rd || vif.vram_addr !== 10'(exp_addr)) e_rd++;
      if (vif.vram_rd_en === 1'b1 && t < 21760) begin
        reads++;
        last_rd = t;
      end
      if (t >= 2) begin
        ph = (t - 2) % 160;
        pv = ((t - 2) / 160) % 136;
      end
      exp_pv  = (t >= 2) && (ph < 128) && (pv < 128);
      exp_pix = exp_pv ? mem[pv * 8 + ph / 16][15 - ph % 16] : 1'b0;
      exp_hs  = (t >= 2) && (ph >= 136) && (ph < 144);
      exp_vs  = (t >= 2) && (pv >= 130) && (pv < 132);
      exp_fs  = (t >= 2) && (ph == 0) && (pv == 0);
      if (pixel !== exp_pix) e_pix++;
      if (pixel_valid !== exp_pv) e_pv++;
      if (hsync !== exp_hs) e_hs++;
      if (vsync !== exp_vs) e_vs++;
      if (frame_start !== exp_fs) e_fs++;
      if (t < 21760 && hsync === 1'b1) hs_cnt++;
      if (t < 21760 && vsync === 1'b1) vs_cnt++;

      if (t == 0)  chk("f0_rd_addr0", {vif.vram_rd_en, vif.vram_addr}, {1'b1, 10'd0});
      if (t == 1)  chk("f0_clk1_quiet", {pixel, pixel_valid, frame_start}, 0);
      if (t == 2)  chk("f0_clk2_pix_fs", {pixel, pixel_valid, frame_start}, 3'b111);
      if (t >= 3 && t <= 16) chk("f0_word0_mid_bits", {pixel, frame_start}, 0);
      if (t == 16) chk("f0_rd_addr1", {vif.vram_rd_en, vif.vram_addr}, {1'b1, 10'd1});
      if (t == 17) chk("f0_clk17_pix", pixel, 1);
      if (t == 137) chk("hsync_pre", hsync, 0);
      if (t == 138) chk("hsync_first", hsync, 1);
      if (t == 145) chk("hsync_last", hsync, 1);
      if (t == 146) chk("hsync_post", hsync, 0);
      if (t == 130 * 160 + 1) chk("vsync_pre", vsync, 0);
      if (t == 130 * 160 + 2) chk("vsync_first", vsync, 1);
      if (t == 132 * 160 + 1) chk("vsync_last", vsync, 1);
      if (t == 132 * 160 + 2) chk("vsync_post", vsync, 0);
      if (t == 21760) chk("f1_wrap_addr0", {vif.vram_rd_en, vif.vram_addr}, {1'b1, 10'd0});
      if (t == 21762) chk("f1_frame_start", frame_start, 1);
    end
    chk("f0_reads", reads, 1024);
    chk("f0_last_rd_h", last_rd % 160, 112);
    chk("f0_last_rd_v", last_rd / 160, 127);
    chk("rd_addr_seq_errs", e_rd, 0);
    chk("pixel_errs", e_pix, 0);
    chk("pixel_valid_errs", e_pv, 0);
    chk("hsync_errs", e_hs, 0);
    chk("vsync_errs", e_vs, 0);
    chk("frame_start_errs", e_fs, 0);
    chk("hsync_clks_f0", hs_cnt, 136 * 8);
    chk("vsync_clks_f0", vs_cnt, 2 * 160);

    // 4: drop enable at v=50 of frame 1; frame must complete then go idle
    for (t = 21763; t < 21760 + 50 * 160; t++) step();
    step();
    chk("f1_v50_rd_addr", {vif.vram_rd_en, vif.vram_addr}, {1'b1, 10'd400});
    enable = 1'b0;
    reads = 0;
    for (t = 21760 + 50 * 160; t < 2 * 21760; t++) begin
      if (t != 21760 + 50 * 160) step();
      if (vif.vram_rd_en === 1'b1) reads++;
    end
    chk("f1_reads_after_drop", reads, 78 * 8);
    for (int i = 0; i < 200; i++) begin
      step();
      if (i == 0) chk("idle_state", 32'(dut.state), 0);
      if (outs !== 6'd0) e_idle++;
    end
    chk("idle_quiet", e_idle, 0);
    enable = 1'b1;
    step();
    chk("restart_addr0", {vif.vram_rd_en, vif.vram_addr}, {1'b1, 10'd0});
    step();
    step();
    chk("restart_pix_fs", {pixel, pixel_valid, frame_start}, 3'b111);

    // 5: reset at h=37 v=10
    for (s = 3; s <= 1637; s++) step();
    chk("pre_reset_hv", {dut.v, dut.h}, {8'd10, 8'd37});
    chk("pre_reset_visible", pixel_valid, 1);
    reset = 1'b0;
    step();
    chk("rst_outs", 32'(outs), 0);
    chk("rst_hv", {dut.h, dut.v}, 0);
    chk("rst_shift", dut.shift_reg, 0);
    reset = 1'b1;
    step();
    chk("rst_restart_addr0", {vif.vram_rd_en, vif.vram_addr}, {1'b1, 10'd0});
    step();
    chk("rst_no_stale", {pixel, pixel_valid, frame_start}, 0);
    step();
    chk("rst_pix_fs", {pixel, pixel_valid, frame_start}, 3'b111);
    e_pix = 0;
    for (s = 3; s <= 16; s++) begin
      step();
      if (pixel !== 1'b0) e_pix++;
    end
    chk("rst_word0_mid_bits", e_pix, 0);
    step();
    chk("rst_clk17_pix", pixel, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
